// File: rtl/filter_ctl_if.sv
// Handshake and memory/filter/destination buses of the filter sequencing controller.
// The controller attaches through the slave modport; its environment drives the master side.
interface filter_ctl_if #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             start;
  logic             filter_en;
  logic [AW-1:0]    src_addr;
  logic [WIDTH-1:0] src_duty;
  logic [WIDTH-1:0] src_phase;
  logic             flt_din_valid;
  logic [WIDTH-1:0] flt_duty;
  logic [WIDTH-1:0] flt_phase;
  logic [WIDTH-1:0] flt_duty_f;
  logic [WIDTH-1:0] flt_phase_f;
  logic             flt_dout_valid;
  logic             dst_we;
  logic [AW-1:0]    dst_addr;
  logic [WIDTH-1:0] dst_duty;
  logic [WIDTH-1:0] dst_phase;
  logic             busy;
  logic             done;
  logic             overrun;

  modport slave (
    input  start, filter_en, src_duty, src_phase, flt_duty_f, flt_phase_f, flt_dout_valid,
    output src_addr, flt_din_valid, flt_duty, flt_phase, dst_we, dst_addr, dst_duty, dst_phase,
           busy, done, overrun
  );

  modport master (
    output start, filter_en, src_duty, src_phase, flt_duty_f, flt_phase_f, flt_dout_valid,
    input  src_addr, flt_din_valid, flt_duty, flt_phase, dst_we, dst_addr, dst_duty, dst_phase,
           busy, done, overrun
  );
endinterface

// File: rtl/filter_ctl.sv
// Frame sequencer: reads DEPTH source entries, routes them through the filter or straight
// across, and writes the result to destination memory with a one-deep request queue.
module filter_ctl #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 249
) (
  input logic          clk,
  input logic          rst_n,
  filter_ctl_if.slave  bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, FIN} state_t;

  state_t        state;
  logic          run_mode;
  logic          pending;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;
  logic [5:0]    idle_cnt;
  logic          busy_r;
  logic          done_r;
  logic          overrun_r;
  logic          din_valid_r;
  logic          byp_vld_p1;
  logic [AW-1:0] byp_addr_p1;

  logic streaming;
  logic wr_room;
  logic flt_we;
  logic byp_we;
  logic we;

  always_comb begin
    streaming = (state == FETCH) || (state == DRAIN);
    wr_room   = (wr_cnt < FULL);
    flt_we    = run_mode && streaming && bus.flt_dout_valid && wr_room;
    byp_we    = !run_mode && byp_vld_p1 && wr_room;
    we        = flt_we || byp_we;
  end

  // Source data arrives one cycle after its address; the filter sees it unregistered.
  assign bus.src_addr      = rd_cnt[AW-1:0];
  assign bus.flt_duty      = (busy_r && run_mode) ? bus.src_duty  : '0;
  assign bus.flt_phase     = (busy_r && run_mode) ? bus.src_phase : '0;
  assign bus.flt_din_valid = din_valid_r;

  assign bus.dst_we    = we;
  assign bus.dst_addr  = !we ? '0 : (run_mode ? wr_cnt[AW-1:0] : byp_addr_p1);
  assign bus.dst_duty  = !we ? '0 : (run_mode ? bus.flt_duty_f  : bus.src_duty);
  assign bus.dst_phase = !we ? '0 : (run_mode ? bus.flt_phase_f : bus.src_phase);

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.overrun = overrun_r;

  // Bypass stage p1: address of the fetch issued last cycle, aligned with its read data.
  always_ff @(posedge clk) begin
    byp_addr_p1 <= rd_cnt[AW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      run_mode    <= 1'b0;
      pending     <= 1'b0;
      rd_cnt      <= '0;
      wr_cnt      <= '0;
      idle_cnt    <= '0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
      din_valid_r <= 1'b0;
      byp_vld_p1  <= 1'b0;
    end else begin
      done_r      <= 1'b0;
      overrun_r   <= 1'b0;
      din_valid_r <= 1'b0;
      byp_vld_p1  <= (state == FETCH) && !run_mode;
      if (we) wr_cnt <= wr_cnt + 1'b1;

      // Requests arriving mid-run queue once; further ones are coalesced and flagged.
      if (bus.start && state != IDLE) begin
        if (pending) overrun_r <= 1'b1;
        pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.start || pending) begin
            state    <= FETCH;
            run_mode <= bus.filter_en;
            pending  <= 1'b0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            idle_cnt <= '0;
            busy_r   <= 1'b1;
          end
        end
        FETCH: begin
          if (rd_cnt == '0 && run_mode) din_valid_r <= 1'b1;
          if (rd_cnt == LAST) state <= DRAIN;
          else                rd_cnt <= rd_cnt + 1'b1;
        end
        DRAIN: begin
          if (wr_cnt == FULL || (we && wr_cnt == LAST)) begin
            state  <= FIN;
            busy_r <= 1'b0;
            done_r <= 1'b1;
          end else if (we) begin
            idle_cnt <= '0;
          end else if (idle_cnt == 6'd63) begin
            state     <= FIN;
            busy_r    <= 1'b0;
            done_r    <= 1'b1;
            overrun_r <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_filter_ctl.sv
// Randomized bench for filter_ctl: source memory and filter models drive the DUT and a
// monitor collects destination writes for comparison against the expected frame.
module tb_filter_ctl;
  localparam int WIDTH = 13;
  localparam int DEPTH = 249;
  localparam int AW    = $clog2(DEPTH);

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] p;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  filter_ctl_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  filter_ctl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Source memory with one-cycle read latency.
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] mem_p [DEPTH];
  always @(posedge clk) begin
    bus.src_duty  <= mem_d[bus.src_addr];
    bus.src_phase <= mem_p[bus.src_addr];
  end

  // Filter model: zero-offset pass-through of DEPTH entries with a fixed latency.
  logic [2:0]       lat_idx = 3'd1;
  bit               flt_on = 1'b1;
  int               flt_left;
  logic             pv [8];
  logic [WIDTH-1:0] pd [8];
  logic [WIDTH-1:0] pp [8];
  always @(posedge clk) begin
    if (!rst_n) begin
      flt_left <= 0;
      for (int i = 0; i < 8; i++) pv[i] <= 1'b0;
    end else begin
      if (bus.flt_din_valid) flt_left <= DEPTH - 1;
      else if (flt_left > 0) flt_left <= flt_left - 1;
      pv[0] <= flt_on && (bus.flt_din_valid || flt_left > 0);
      for (int i = 1; i < 8; i++) pv[i] <= pv[i-1];
    end
    pd[0] <= bus.flt_duty;
    pp[0] <= bus.flt_phase;
    for (int i = 1; i < 8; i++) begin
      pd[i] <= pd[i-1];
      pp[i] <= pp[i-1];
    end
  end
  assign bus.flt_dout_valid = pv[lat_idx];
  assign bus.flt_duty_f     = pd[lat_idx];
  assign bus.flt_phase_f    = pp[lat_idx];

  // Monitor
  wr_t  wr_q [$];
  int   wr_cyc [$];
  int   done_cnt = 0, done_cyc = -1, ovr_cnt = 0, ovr_cyc = -1, dv_cnt = 0, dv_cyc = -1;
  int   rise_cyc = -1;
  logic done_busy = 1'b0, busy_d = 1'b0;
  always @(negedge clk) begin
    if (bus.dst_we) begin
      wr_q.push_back({bus.dst_addr, bus.dst_duty, bus.dst_phase});
      wr_cyc.push_back(cyc);
    end
    if (bus.done) begin
      done_cnt++;
      done_cyc  = cyc;
      done_busy = bus.busy;
    end
    if (bus.overrun) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (bus.flt_din_valid) begin
      dv_cnt++;
      dv_cyc = cyc;
    end
    if (bus.busy && !busy_d) rise_cyc = cyc;
    busy_d = bus.busy;
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic fill(input bit ramp);
    for (int k = 0; k < DEPTH; k++) begin
      mem_d[k] = ramp ? WIDTH'(k)     : WIDTH'($urandom);
      mem_p[k] = ramp ? WIDTH'(2 * k) : WIDTH'($urandom);
    end
  endtask

  task automatic pulse_start(output int s);
    bus.start = 1'b1;
    s = cyc;
    tick(1);
    bus.start = 1'b0;
  endtask

  task automatic wait_cyc(input int target);
    while (cyc < target) tick(1);
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      tick(1);
      n++;
    end
    check_eq({tag, "_done_in_time"}, 64'(done_cnt >= target), 64'd1);
  endtask

  // Expected frame: entry k lands at address k with the source word k.
  task automatic check_frame(input string tag, input int base);
    wr_t exp_w;
    check_eq({tag, "_nwrites"}, 64'(wr_q.size() >= base + DEPTH), 64'd1);
    for (int k = 0; k < DEPTH; k++) begin
      if (base + k < wr_q.size()) begin
        exp_w = {AW'(k), mem_d[k], mem_p[k]};
        check_eq($sformatf("%s_w%0d", tag, k), 64'(wr_q[base + k]), 64'(exp_w));
      end
    end
  endtask

  initial begin
    int s, s2, s3, base, d0, o0, v0, dc1;
    bus.start = 1'b0;
    bus.filter_en = 1'b0;
    fill(1'b0);
    tick(3);

    // Reset state
    check_eq("rst_busy", 64'(bus.busy), 64'd0);
    check_eq("rst_done", 64'(bus.done), 64'd0);
    check_eq("rst_overrun", 64'(bus.overrun), 64'd0);
    check_eq("rst_dst_we", 64'(bus.dst_we), 64'd0);
    check_eq("rst_din_valid", 64'(bus.flt_din_valid), 64'd0);
    check_eq("rst_src_addr", 64'(bus.src_addr), 64'd0);
    check_eq("rst_dst_addr", 64'(bus.dst_addr), 64'd0);
    check_eq("rst_dst_data", 64'({bus.dst_duty, bus.dst_phase}), 64'd0);
    check_eq("rst_flt_data", 64'({bus.flt_duty, bus.flt_phase}), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // Filtered run, ramp data
    fill(1'b1);
    lat_idx = 3'($urandom_range(0, 5));
    bus.filter_en = 1'b1;
    base = wr_q.size(); d0 = done_cnt; o0 = ovr_cnt; v0 = dv_cnt;
    pulse_start(s);
    wait_done("flt", d0 + 1, 700);
    tick(3);
    check_frame("flt", base);
    check_eq("flt_exact_writes", 64'(wr_q.size() - base), 64'(DEPTH));
    check_eq("flt_din_valid_cnt", 64'(dv_cnt - v0), 64'd1);
    check_eq("flt_din_valid_cyc", 64'(dv_cyc), 64'(s + 2));
    check_eq("flt_done_cnt", 64'(done_cnt - d0), 64'd1);
    check_eq("flt_busy_at_done", 64'(done_busy), 64'd0);
    check_eq("flt_no_overrun", 64'(ovr_cnt - o0), 64'd0);

    // Bypass run, random data
    fill(1'b0);
    bus.filter_en = 1'b0;
    base = wr_q.size(); d0 = done_cnt; v0 = dv_cnt;
    pulse_start(s);
    wait_done("byp", d0 + 1, 700);
    tick(3);
    check_frame("byp", base);
    check_eq("byp_exact_writes", 64'(wr_q.size() - base), 64'(DEPTH));
    check_eq("byp_no_din_valid", 64'(dv_cnt - v0), 64'd0);
    check_eq("byp_first_wr_cyc", 64'(wr_cyc[base]), 64'(s + 2));
    check_eq("byp_last_wr_cyc", 64'(wr_cyc[base + DEPTH - 1]), 64'(s + 250));
    check_eq("byp_done_cyc", 64'(done_cyc), 64'(s + 251));

    // One queued request
    fill(1'b0);
    base = wr_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    pulse_start(s);
    wait_cyc(s + 10);
    pulse_start(s2);
    wait_done("q1a", d0 + 1, 700);
    dc1 = done_cyc;
    wait_done("q1b", d0 + 2, 700);
    tick(3);
    check_frame("q1_run1", base);
    check_frame("q1_run2", base + DEPTH);
    check_eq("q1_writes", 64'(wr_q.size() - base), 64'(2 * DEPTH));
    check_eq("q1_restart_cyc", 64'(rise_cyc), 64'(dc1 + 2));
    check_eq("q1_no_overrun", 64'(ovr_cnt - o0), 64'd0);

    // Coalesced third request
    base = wr_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    pulse_start(s);
    wait_cyc(s + 10);
    pulse_start(s2);
    wait_cyc(s + 20);
    pulse_start(s3);
    wait_done("q2", d0 + 2, 1200);
    tick(300);
    check_eq("q2_overrun_cnt", 64'(ovr_cnt - o0), 64'd1);
    check_eq("q2_overrun_cyc", 64'(ovr_cyc), 64'(s3 + 1));
    check_eq("q2_runs", 64'(done_cnt - d0), 64'd2);
    check_eq("q2_writes", 64'(wr_q.size() - base), 64'(2 * DEPTH));

    // Filter never answers
    flt_on = 1'b0;
    bus.filter_en = 1'b1;
    base = wr_q.size(); d0 = done_cnt; o0 = ovr_cnt;
    pulse_start(s);
    wait_done("tmo", d0 + 1, 700);
    tick(2);
    check_eq("tmo_overrun_cnt", 64'(ovr_cnt - o0), 64'd1);
    check_eq("tmo_overrun_cyc", 64'(ovr_cyc), 64'(s + 314));
    check_eq("tmo_done_cyc", 64'(done_cyc), 64'(s + 314));
    check_eq("tmo_no_writes", 64'(wr_q.size() - base), 64'd0);
    check_eq("tmo_idle_busy", 64'(bus.busy), 64'd0);
    flt_on = 1'b1;

    // Reset in the middle of a run
    fill(1'b0);
    bus.filter_en = 1'b0;
    d0 = done_cnt;
    pulse_start(s);
    for (int n = 0; n < 400 && bus.src_addr != AW'(100); n++) tick(1);
    check_eq("mid_reached_100", 64'(bus.src_addr), 64'd100);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    check_eq("mid_rst_busy", 64'(bus.busy), 64'd0);
    check_eq("mid_rst_we", 64'(bus.dst_we), 64'd0);
    check_eq("mid_rst_addrs", 64'({bus.src_addr, bus.dst_addr}), 64'd0);
    check_eq("mid_rst_data", 64'({bus.dst_duty, bus.dst_phase, bus.flt_duty, bus.flt_phase}), 64'd0);
    check_eq("mid_rst_flags", 64'({bus.done, bus.overrun, bus.flt_din_valid}), 64'd0);
    base = wr_q.size();
    tick(300);
    check_eq("mid_no_done", 64'(done_cnt - d0), 64'd0);
    check_eq("mid_no_writes", 64'(wr_q.size() - base), 64'd0);
    fill(1'b0);
    bus.filter_en = 1'b1;
    lat_idx = 3'($urandom_range(0, 5));
    pulse_start(s);
    wait_done("rerun", d0 + 1, 700);
    tick(3);
    check_frame("rerun", base);
    check_eq("rerun_exact_writes", 64'(wr_q.size() - base), 64'(DEPTH));

    // Mode change mid-run
    fill(1'b0);
    bus.filter_en = 1'b1;
    base = wr_q.size(); d0 = done_cnt; v0 = dv_cnt;
    pulse_start(s);
    tick(50);
    bus.filter_en = 1'b0;
    wait_done("tog1", d0 + 1, 700);
    tick(3);
    check_frame("tog_run1", base);
    check_eq("tog_run1_din_valid", 64'(dv_cnt - v0), 64'd1);
    fill(1'b0);
    base = wr_q.size();
    pulse_start(s);
    wait_done("tog2", d0 + 2, 700);
    tick(3);
    check_frame("tog_run2", base);
    check_eq("tog_run2_din_valid", 64'(dv_cnt - v0), 64'd1);
    check_eq("tog_run2_first_wr", 64'(wr_cyc[base]), 64'(s + 2));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
